// File: rtl/div_param.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) using restoring division that
// retires BITS_PER_CYCLE quotient bits per cycle; all outputs are registered.
module div_param #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int REG_ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      dividend_i,
    input  logic [WIDTH-1:0]      divisor_i,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [REG_ADDR_W-1:0] reg_waddr_i,
    output logic [WIDTH-1:0]      result_o,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic [REG_ADDR_W-1:0] reg_waddr_o
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_START = 4'b0010,
        S_CALC  = 4'b0100,
        S_END   = 4'b1000
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]      dvd_q, dvd_d;
    logic [WIDTH-1:0]      dsr_q, dsr_d;
    logic [WIDTH-1:0]      quot_q, quot_d;
    logic [WIDTH-1:0]      rem_q, rem_d;
    logic [2:0]            op_q, op_d;
    logic                  neg_q, neg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]      result_d;
    logic                  ready_d, busy_d;
    logic [REG_ADDR_W-1:0] waddr_d;

    logic [WIDTH:0]        trial;
    logic [WIDTH-1:0]      calc_rem, calc_dvd, calc_quot, sel;
    logic                  is_signed, is_rem, dvd_neg, dsr_neg;

    // Signed only for the divide group's DIV/REM encodings
    assign is_signed = op_q[2] & ~op_q[0];
    assign is_rem    = op_q[1];
    assign dvd_neg   = is_signed & dvd_q[WIDTH-1];
    assign dsr_neg   = is_signed & dsr_q[WIDTH-1];
    assign sel       = is_rem ? rem_q : quot_q;

    // The dividend register doubles as the bit source, shifted out MSB first
    always_comb begin
        calc_rem  = rem_q;
        calc_dvd  = dvd_q;
        calc_quot = quot_q;
        trial     = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            trial    = {calc_rem, calc_dvd[WIDTH-1]};
            calc_dvd = calc_dvd << 1;
            if (trial >= {1'b0, dsr_q}) begin
                calc_rem  = trial[WIDTH-1:0] - dsr_q;
                calc_quot = {calc_quot[WIDTH-2:0], 1'b1};
            end else begin
                calc_rem  = trial[WIDTH-1:0];
                calc_quot = {calc_quot[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = '0;
        ready_d  = 1'b0;
        busy_d   = 1'b0;
        waddr_d  = reg_waddr_o;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    dvd_d   = dividend_i;
                    dsr_d   = divisor_i;
                    op_d    = op_i;
                    waddr_d = reg_waddr_i;
                    busy_d  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (!start_i) begin
                    waddr_d = '0;
                    state_d = S_IDLE;
                end else if (dsr_q == '0) begin
                    result_d = is_rem ? dvd_q : '1;
                    ready_d  = 1'b1;
                    state_d  = S_IDLE;
                end else if (is_signed && dvd_q == MIN_INT && dsr_q == '1) begin
                    result_d = is_rem ? '0 : dvd_q;
                    ready_d  = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    dvd_d   = dvd_neg ? -dvd_q : dvd_q;
                    dsr_d   = dsr_neg ? -dsr_q : dsr_q;
                    neg_d   = is_rem ? dvd_neg : (dvd_neg ^ dsr_neg);
                    quot_d  = '0;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(N);
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (!start_i) begin
                    waddr_d = '0;
                    state_d = S_IDLE;
                end else begin
                    dvd_d  = calc_dvd;
                    quot_d = calc_quot;
                    rem_d  = calc_rem;
                    cnt_d  = cnt_q - CNT_W'(1);
                    busy_d = 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_END;
                    end
                end
            end
            S_END: begin
                if (!start_i) begin
                    waddr_d = '0;
                end else begin
                    result_d = neg_q ? -sel : sel;
                    ready_d  = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                waddr_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            dvd_q       <= '0;
            dsr_q       <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            result_o    <= '0;
            ready_o     <= 1'b0;
            busy_o      <= 1'b0;
            reg_waddr_o <= '0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            result_o    <= result_d;
            ready_o     <= ready_d;
            busy_o      <= busy_d;
            reg_waddr_o <= waddr_d;
        end
    end

endmodule

// File: tb/tb_div_param.sv
// Scoreboard bench: three div_param instances (1, 2 and 4 bits per cycle) run
// the same operations and are checked against a plain-arithmetic divide model.
module tb_div_param;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam logic [W-1:0] MIN_INT = 32'h8000_0000;

    typedef struct {
        logic [W-1:0]  res;
        logic [AW-1:0] addr;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  dividend, divisor;
    logic [2:0]    op;
    logic [AW-1:0] waddr;
    logic [2:0]    start;

    logic [W-1:0]  res0, res1, res2;
    logic          rdy0, rdy1, rdy2;
    logic          busy0, busy1, busy2;
    logic [AW-1:0] wa0, wa1, wa2;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb0[$], sb1[$], sb2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_param #(.WIDTH(W), .BITS_PER_CYCLE(1), .REG_ADDR_W(AW)) dut1 (
        .clk(clk), .rst(rst), .dividend_i(dividend), .divisor_i(divisor),
        .start_i(start[0]), .op_i(op), .reg_waddr_i(waddr),
        .result_o(res0), .ready_o(rdy0), .busy_o(busy0), .reg_waddr_o(wa0)
    );
    div_param #(.WIDTH(W), .BITS_PER_CYCLE(2), .REG_ADDR_W(AW)) dut2 (
        .clk(clk), .rst(rst), .dividend_i(dividend), .divisor_i(divisor),
        .start_i(start[1]), .op_i(op), .reg_waddr_i(waddr),
        .result_o(res1), .ready_o(rdy1), .busy_o(busy1), .reg_waddr_o(wa1)
    );
    div_param #(.WIDTH(W), .BITS_PER_CYCLE(4), .REG_ADDR_W(AW)) dut4 (
        .clk(clk), .rst(rst), .dividend_i(dividend), .divisor_i(divisor),
        .start_i(start[2]), .op_i(op), .reg_waddr_i(waddr),
        .result_o(res2), .ready_o(rdy2), .busy_o(busy2), .reg_waddr_o(wa2)
    );

    // Reference: RISC-V M-extension division semantics in plain arithmetic
    function automatic logic [W-1:0] ref_result(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa, sbv;
        sa  = a;
        sbv = b;
        case (o)
            3'b100:  return (b == 0) ? '1 : (a == MIN_INT && b == '1) ? a : W'(sa / sbv);
            3'b101:  return (b == 0) ? '1 : a / b;
            3'b110:  return (b == 0) ? a : (a == MIN_INT && b == '1) ? '0 : W'(sa % sbv);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int bpc);
        bit special;
        special = (b == 0) || (!o[0] && a == MIN_INT && b == '1);
        return special ? 2 : (W / bpc) + 3;
    endfunction

    task automatic checkOutput(input int k, input logic [W-1:0] r, input logic rd, input logic bz, input logic [AW-1:0] wa);
        exp_t e;
        bit   have;
        have   = 0;
        e.res  = '0;
        e.addr = '0;
        e.cyc  = 0;
        if (rd === 1'b1) begin
            case (k)
                0: if (sb0.size() > 0) begin e = sb0.pop_front(); have = 1; end
                1: if (sb1.size() > 0) begin e = sb1.pop_front(); have = 1; end
                default: if (sb2.size() > 0) begin e = sb2.pop_front(); have = 1; end
            endcase
            checks++;
            if (!have) begin
                failures++;
                $display("[TB] FAIL unexpected_ready dut%0d: got result=%h, required no ready pulse", k, r);
            end else begin
                if (r !== e.res) begin
                    failures++;
                    $display("[TB] FAIL result dut%0d: got %h, required %h", k, r, e.res);
                end
                checks++;
                if (wa !== e.addr) begin
                    failures++;
                    $display("[TB] FAIL reg_waddr dut%0d: got %h, required %h", k, wa, e.addr);
                end
                checks++;
                if (cyc != e.cyc) begin
                    failures++;
                    $display("[TB] FAIL ready_cycle dut%0d: got %0d, required %0d", k, cyc, e.cyc);
                end
                checks++;
                if (bz !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL busy_at_ready dut%0d: got %b, required 0", k, bz);
                end
            end
        end else begin
            checks++;
            if (r !== '0) begin
                failures++;
                $display("[TB] FAIL idle_result dut%0d: got %h, required 0", k, r);
            end
        end
    endtask

    always @(posedge clk) begin #1; checkOutput(0, res0, rdy0, busy0, wa0); end
    always @(posedge clk) begin #1; checkOutput(1, res1, rdy1, busy1, wa1); end
    always @(posedge clk) begin #1; checkOutput(2, res2, rdy2, busy2, wa2); end

    task automatic expectZero(input string name, input logic [W-1:0] r, input logic rd, input logic bz, input logic [AW-1:0] wa);
        checks++;
        if (r !== '0 || rd !== 1'b0 || bz !== 1'b0 || wa !== '0) begin
            failures++;
            $display("[TB] FAIL %s: got result=%h ready=%b busy=%b waddr=%h, required all 0", name, r, rd, bz, wa);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic [AW-1:0] addr);
        exp_t e;
        int   acc, n;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        op       = o;
        waddr    = addr;
        acc      = cyc + 1;
        e.res    = ref_result(o, a, b);
        e.addr   = addr;
        e.cyc    = acc + ref_latency(o, a, b, 1) - 1;
        sb0.push_back(e);
        e.cyc    = acc + ref_latency(o, a, b, 2) - 1;
        sb1.push_back(e);
        e.cyc    = acc + ref_latency(o, a, b, 4) - 1;
        sb2.push_back(e);
        start = 3'b111;
        n = 0;
        while (start != 3'b000 && n < 60) begin
            @(posedge clk);
            #1;
            if (start[0] && rdy0) start[0] = 1'b0;
            if (start[1] && rdy1) start[1] = 1'b0;
            if (start[2] && rdy2) start[2] = 1'b0;
            n++;
        end
        if (start != 3'b000) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout: start still held %b after %0d cycles, required all ready", start, n);
            start = 3'b000;
            sb0.delete();
            sb1.delete();
            sb2.delete();
        end
    endtask

    logic [2:0] d_op [13] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b110, 3'b101, 3'b110,
                              3'b100, 3'b110, 3'b101, 3'b111, 3'b101, 3'b100};
    logic [W-1:0] d_a [13] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'd5,
                               32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'h8000_0000, 32'd5};
    logic [W-1:0] d_b [13] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                               32'hFFFF_FFFF, 32'd0};

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return MIN_INT;
            3:       return W'($urandom_range(1, 20));
            default: return W'($urandom());
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        rst      = 1'b0;
        start    = 3'b000;
        dividend = '0;
        divisor  = '0;
        op       = 3'b101;
        waddr    = '0;
        repeat (3) @(posedge clk);
        #1;
        expectZero("reset_dut1", res0, rdy0, busy0, wa0);
        expectZero("reset_dut2", res1, rdy1, busy1, wa1);
        expectZero("reset_dut4", res2, rdy2, busy2, wa2);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(d_op[i], d_a[i], d_b[i], AW'(i + 1));
        end

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 3);
            applyStimulus(3'b100 | 3'(r), rnd_operand(), rnd_operand(), AW'($urandom_range(0, 31)));
        end

        // Abort the 1-bit instance in its tenth CALC cycle
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd3;
        op       = 3'b101;
        waddr    = 5'd9;
        start[0] = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        checks++;
        if (busy0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL busy_before_abort: got %b, required 1", busy0);
        end
        @(negedge clk);
        start[0] = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy0 !== 1'b0 || rdy0 !== 1'b0 || res0 !== '0) begin
            failures++;
            $display("[TB] FAIL abort: got busy=%b ready=%b result=%h, required 0/0/0", busy0, rdy0, res0);
        end
        repeat (40) @(posedge clk);

        // Reset while every instance is mid-CALC
        @(negedge clk);
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'd13;
        op       = 3'b101;
        waddr    = 5'd21;
        start    = 3'b111;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        expectZero("midcalc_reset_dut1", res0, rdy0, busy0, wa0);
        expectZero("midcalc_reset_dut2", res1, rdy1, busy1, wa1);
        expectZero("midcalc_reset_dut4", res2, rdy2, busy2, wa2);
        @(negedge clk);
        rst   = 1'b1;
        start = 3'b000;
        repeat (40) @(posedge clk);

        applyStimulus(3'b101, 32'd100, 32'd7, 5'd3);
        repeat (5) @(posedge clk);

        checks++;
        if (sb0.size() + sb1.size() + sb2.size() != 0) begin
            failures++;
            $display("[TB] FAIL pending_results: got %0d outstanding, required 0", sb0.size() + sb1.size() + sb2.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
